// File: rtl/bit_serial_exec_unit.sv
// ---------------------------------------------------------------------------
// bit_serial_exec_unit
//
// Purpose:
//   Holds a small register file and executes one two-operand ALU instruction
//   per request. The instruction is processed bit-serially, LSB first, with
//   one bit per clock over WIDTH cycles. The result is then committed to the
//   destination register in a single DONE cycle.
//
//   Handshake (start/busy/done):
//     - start is sampled only while idle (busy=0). The accepting edge latches
//       op/rd/rs1/rs2 and snapshots both source registers.
//     - busy is high for the WIDTH+1 cycles spent in EXEC and DONE. While
//       busy is high, start and wr_en are ignored; nothing is queued.
//     - done pulses high for exactly one cycle after the commit edge. In that
//       cycle the unit is already idle, so a new start is accepted there.
//     - If start and wr_en are both high in the same idle cycle, start wins
//       and the load is dropped.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               instruction request
//   op, rd, rs1, rs2    opcode and register indices, sampled with start
//   wr_en, wr_addr,
//   wr_data             parallel register load (idle, start low)
//   rd_addr, rd_data    combinational read port
//   busy, done          handshake status
//   c_flag, z_flag      carry and zero flags, updated at commit
//   n_flag, v_flag      sign and signed-overflow flags (SIGNED_FLAGS_EN only)
//
// Configuration:
//   SIGNED_FLAGS_EN - when defined, adds the n_flag/v_flag outputs.
// ---------------------------------------------------------------------------
module bit_serial_exec_unit #(
  parameter int WIDTH = 8,
  parameter int REGS  = 4,
  localparam int AW   = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             c_flag,
`ifdef SIGNED_FLAGS_EN
  output logic             n_flag,
  output logic             v_flag,
`endif
  output logic             z_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_SHR1 = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_regs [REGS];
  logic [2:0]         r_op;
  logic [AW-1:0]      r_rd;
  logic [WIDTH-1:0]   r_a;      // rs1 snapshot, shifts right each EXEC cycle
  logic [WIDTH-1:0]   r_b;      // rs2 snapshot, shifts right each EXEC cycle
  logic [WIDTH-1:0]   r_res;    // result, filled from the MSB end
  logic [CW-1:0]      r_cnt;
  // Carry chain for ADD/SUB. It doubles as the previous rs1 bit for SHL1 and
  // holds rs1[0] for SHR1, so it is the c_flag source for all four ops.
  logic               r_carry;
  logic               r_done;
  logic               r_c_flag;
  logic               r_z_flag;
`ifdef SIGNED_FLAGS_EN
  logic               r_cin_msb; // carry into bit WIDTH-1, for overflow
  logic               r_n_flag;
  logic               r_v_flag;
`endif

  logic               w_a;
  logic               w_b;
  logic               w_bx;
  logic               w_sum;
  logic               w_cout;
  logic               w_bit;
  logic               w_carry_nxt;
  logic               w_last;
  logic               w_arith;

  // One bit of the serial ALU.
  always_comb begin
    w_a         = r_a[0];
    w_b         = r_b[0];
    w_bx        = (r_op == OP_SUB) ? ~w_b : w_b;
    w_sum       = w_a ^ w_bx ^ r_carry;
    w_cout      = (w_a & w_bx) | (w_a & r_carry) | (w_bx & r_carry);
    w_arith     = (r_op == OP_ADD) || (r_op == OP_SUB);
    w_bit       = 1'b0;
    w_carry_nxt = r_carry;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_bit       = w_sum;
        w_carry_nxt = w_cout;
      end
      OP_AND:  w_bit = w_a & w_b;
      OP_OR:   w_bit = w_a | w_b;
      OP_XOR:  w_bit = w_a ^ w_b;
      OP_MOV:  w_bit = w_a;
      OP_SHL1: begin
        w_bit       = r_carry;   // previous rs1 bit, 0 at bit 0
        w_carry_nxt = w_a;
      end
      OP_SHR1: w_bit = r_a[1];   // zero-filled shift brings 0 at the MSB
      default: w_bit = 1'b0;
    endcase
    w_last = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_c_flag <= 1'b0;
      r_z_flag <= 1'b0;
`ifdef SIGNED_FLAGS_EN
      r_cin_msb <= 1'b0;
      r_n_flag  <= 1'b0;
      r_v_flag  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_rd    <= rd;
            r_a     <= r_regs[rs1];
            r_b     <= r_regs[rs2];
            r_cnt   <= '0;
            if (op == OP_SUB)       r_carry <= 1'b1;
            else if (op == OP_SHR1) r_carry <= r_regs[rs1][0];
            else                    r_carry <= 1'b0;
            r_state <= S_EXEC;
          end else if (wr_en) begin
            r_regs[wr_addr] <= wr_data;
          end
        end
        S_EXEC: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_res   <= {w_bit, r_res[WIDTH-1:1]};
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + 1'b1;
`ifdef SIGNED_FLAGS_EN
          if (w_last) r_cin_msb <= r_carry;
`endif
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_regs[r_rd] <= r_res;
          r_z_flag     <= (r_res == '0);
          r_c_flag     <= (w_arith || r_op == OP_SHL1 || r_op == OP_SHR1)
                          ? r_carry : 1'b0;
`ifdef SIGNED_FLAGS_EN
          r_n_flag     <= r_res[WIDTH-1];
          r_v_flag     <= w_arith ? (r_cin_msb ^ r_carry) : 1'b0;
`endif
          r_done       <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data = r_regs[rd_addr];
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign c_flag  = r_c_flag;
  assign z_flag  = r_z_flag;
`ifdef SIGNED_FLAGS_EN
  assign n_flag  = r_n_flag;
  assign v_flag  = r_v_flag;
`endif

endmodule

// File: tb/tb_bit_serial_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_exec_unit
//
// Directed bench for bit_serial_exec_unit (WIDTH=8, REGS=4). Each scenario
// task drives its stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bit_serial_exec_unit;

  localparam int WIDTH = 8;
  localparam int REGS  = 4;
  localparam int AW    = 2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_SHR1 = 3'b111;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             c_flag;
  logic             z_flag;
`ifdef SIGNED_FLAGS_EN
  logic             n_flag;
  logic             v_flag;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_cyc = 0;

  bit_serial_exec_unit #(.WIDTH(WIDTH), .REGS(REGS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .c_flag  (c_flag),
`ifdef SIGNED_FLAGS_EN
    .n_flag  (n_flag),
    .v_flag  (v_flag),
`endif
    .z_flag  (z_flag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_reg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  // Issues one instruction from the current (idle) cycle and waits for done.
  // lat counts edges after the accepting edge until done is seen (20 = timeout);
  // bcnt counts sampled cycles with busy high. Returns #1 into the done cycle.
  task automatic run_instr(input logic [2:0] o, input logic [AW-1:0] d,
                           input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           output int lat, output int bcnt);
    start = 1'b1;
    op    = o;
    rd    = d;
    rs1   = s1;
    rs2   = s2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    bcnt  = busy ? 1 : 0;
    lat   = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) break;
      if (busy === 1'b1) bcnt++;
    end
    done_cyc = cyc;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [WIDTH-1:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [WIDTH-1:0] v;
    apply_reset();
    checks++;
    if ({busy, done, c_flag, z_flag} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got busy/done/c/z=%b required 0000",
               {busy, done, c_flag, z_flag});
    end
    for (int a = 0; a < REGS; a++) begin
      peek(AW'(a), v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h required 00", a, v);
      end
    end
  endtask

  task automatic test_add();
    int lat, bc;
    logic [WIDTH-1:0] v;
    write_reg(0, 8'hF0);
    write_reg(1, 8'h25);
    run_instr(OP_ADD, 2, 0, 1, lat, bc);
    checks++;
    if (lat !== WIDTH + 1) begin
      errors++;
      $display("FAIL add_latency: got %0d edges required %0d", lat, WIDTH + 1);
    end
    checks++;
    if (bc !== WIDTH + 1) begin
      errors++;
      $display("FAIL add_busy_cycles: got %0d required %0d", bc, WIDTH + 1);
    end
    checks++;
    if ({c_flag, z_flag} !== 2'b10) begin
      errors++;
      $display("FAIL add_flags: got c/z=%b required 10", {c_flag, z_flag});
    end
    peek(2, v);
    checks++;
    if (v !== 8'h15) begin
      errors++;
      $display("FAIL add_result: got %h required 15", v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_width: got done=%b required 0", done);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    logic [WIDTH-1:0] v;
    write_reg(0, 8'h37);
    run_instr(OP_SUB, 1, 0, 0, lat, bc);
    peek(1, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'h00, 2'b11}) begin
      errors++;
      $display("FAIL sub_zero: got %h c/z=%b required 00 c/z=11",
               v, {c_flag, z_flag});
    end
    write_reg(3, 8'h01);
    run_instr(OP_SUB, 0, 3, 0, lat, bc);
    peek(0, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'hCA, 2'b00}) begin
      errors++;
      $display("FAIL sub_borrow: got %h c/z=%b required CA c/z=00",
               v, {c_flag, z_flag});
    end
  endtask

  task automatic test_shift_logic();
    int lat, bc;
    logic [WIDTH-1:0] v;
    write_reg(1, 8'h81);
    run_instr(OP_SHL1, 2, 1, 0, lat, bc);
    peek(2, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'h02, 2'b10}) begin
      errors++;
      $display("FAIL shl1: got %h c/z=%b required 02 c/z=10", v, {c_flag, z_flag});
    end
    run_instr(OP_SHR1, 2, 1, 0, lat, bc);
    peek(2, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'h40, 2'b10}) begin
      errors++;
      $display("FAIL shr1: got %h c/z=%b required 40 c/z=10", v, {c_flag, z_flag});
    end
    run_instr(OP_XOR, 3, 1, 1, lat, bc);
    peek(3, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'h00, 2'b01}) begin
      errors++;
      $display("FAIL xor_self: got %h c/z=%b required 00 c/z=01", v, {c_flag, z_flag});
    end
    // Flags must hold across idle cycles.
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({c_flag, z_flag} !== 2'b01) begin
      errors++;
      $display("FAIL flags_hold: got c/z=%b required 01", {c_flag, z_flag});
    end
    write_reg(0, 8'hAA);
    write_reg(1, 8'h0F);
    run_instr(OP_AND, 2, 0, 1, lat, bc);
    peek(2, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'h0A, 2'b00}) begin
      errors++;
      $display("FAIL and: got %h c/z=%b required 0A c/z=00", v, {c_flag, z_flag});
    end
    run_instr(OP_OR, 3, 0, 1, lat, bc);
    peek(3, v);
    checks++;
    if (v !== 8'hAF) begin
      errors++;
      $display("FAIL or: got %h required AF", v);
    end
    run_instr(OP_MOV, 3, 0, 1, lat, bc);
    peek(3, v);
    checks++;
    if ({v, c_flag} !== {8'hAA, 1'b0}) begin
      errors++;
      $display("FAIL mov: got %h c=%b required AA c=0", v, c_flag);
    end
    // Fully aliased: r3 = r3 + r3 = 0xAA + 0xAA = 0x154.
    run_instr(OP_ADD, 3, 3, 3, lat, bc);
    peek(3, v);
    checks++;
    if ({v, c_flag, z_flag} !== {8'h54, 2'b10}) begin
      errors++;
      $display("FAIL add_alias: got %h c/z=%b required 54 c/z=10", v, {c_flag, z_flag});
    end
  endtask

  // Registers on entry: r0=AA r1=0F r2=0A r3=54.
  task automatic test_busy_ignore();
    int n;
    int d0;
    logic [WIDTH-1:0] v;
    start = 1'b1; op = OP_ADD; rd = 2; rs1 = 0; rs2 = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    @(posedge clk);
    #1;
    n++;
    wr_en = 1'b1; wr_addr = 0; wr_data = 8'h55;
    start = 1'b1; op = OP_XOR; rd = 1; rs1 = 0; rs2 = 0;
    @(posedge clk);
    #1;
    n++;
    wr_en = 1'b0;
    start = 1'b0;
    peek(2, v);
    checks++;
    if (v !== 8'h0A) begin
      errors++;
      $display("FAIL exec_old_value: got %h required 0A", v);
    end
    while (n < 20 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== WIDTH + 1) begin
      errors++;
      $display("FAIL busy_latency: got %0d edges required %0d", n, WIDTH + 1);
    end
    peek(2, v);
    checks++;
    if (v !== 8'hB9) begin
      errors++;
      $display("FAIL busy_result: got %h required B9", v);
    end
    peek(0, v);
    checks++;
    if (v !== 8'hAA) begin
      errors++;
      $display("FAIL busy_wr_ignored: got r0=%h required AA", v);
    end
    peek(1, v);
    checks++;
    if (v !== 8'h0F) begin
      errors++;
      $display("FAIL busy_start_ignored: got r1=%h required 0F", v);
    end
    d0 = done_seen;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_seen - d0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_second: got %0d extra done, busy=%b required 1, 0",
               done_seen - d0, busy);
    end
  endtask

  task automatic test_start_wr_same();
    int lat, bc;
    logic [WIDTH-1:0] v;
    wr_en = 1'b1; wr_addr = 3; wr_data = 8'h77;
    run_instr(OP_MOV, 2, 1, 0, lat, bc);
    peek(2, v);
    checks++;
    if (v !== 8'h0F) begin
      errors++;
      $display("FAIL start_wins_result: got %h required 0F", v);
    end
    peek(3, v);
    checks++;
    if (v !== 8'h54) begin
      errors++;
      $display("FAIL start_wins_wr_dropped: got r3=%h required 54", v);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, c1;
    logic [WIDTH-1:0] v;
    run_instr(OP_ADD, 2, 0, 1, lat, bc);
    c1 = done_cyc;
    checks++;
    if (rd_data !== rd_data || lat !== WIDTH + 1) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d required %0d", lat, WIDTH + 1);
    end
    // Issued from the done cycle itself.
    run_instr(OP_SUB, 3, 0, 1, lat, bc);
    checks++;
    if (done_cyc - c1 !== WIDTH + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", done_cyc - c1, WIDTH + 2);
    end
    peek(2, v);
    checks++;
    if (v !== 8'hB9) begin
      errors++;
      $display("FAIL b2b_first_result: got %h required B9", v);
    end
    peek(3, v);
    checks++;
    if ({v, c_flag} !== {8'h9B, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second_result: got %h c=%b required 9B c=1", v, c_flag);
    end
  endtask

`ifdef SIGNED_FLAGS_EN
  task automatic test_signed_flags();
    int lat, bc;
    logic [WIDTH-1:0] v;
    write_reg(0, 8'h7F);
    write_reg(1, 8'h01);
    run_instr(OP_ADD, 2, 0, 1, lat, bc);
    peek(2, v);
    checks++;
    if ({v, n_flag, v_flag, c_flag, z_flag} !== {8'h80, 4'b1100}) begin
      errors++;
      $display("FAIL signed_overflow: got %h n/v/c/z=%b required 80 n/v/c/z=1100",
               v, {n_flag, v_flag, c_flag, z_flag});
    end
    run_instr(OP_OR, 3, 0, 1, lat, bc);
    checks++;
    if ({n_flag, v_flag} !== 2'b00) begin
      errors++;
      $display("FAIL signed_logic: got n/v=%b required 00", {n_flag, v_flag});
    end
  endtask
`endif

  task automatic test_reset_mid_exec();
    int lat, bc, d0;
    logic [WIDTH-1:0] v;
    write_reg(0, 8'h13);
    run_instr(OP_SUB, 1, 0, 0, lat, bc);  // leaves c=1, z=1
    start = 1'b1; op = OP_ADD; rd = 2; rs1 = 0; rs2 = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, c_flag, z_flag} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs: got busy/done/c/z=%b required 0000",
               {busy, done, c_flag, z_flag});
    end
    for (int a = 0; a < REGS; a++) begin
      peek(AW'(a), v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL midreset_reg%0d: got %h required 00", a, v);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    peek(2, v);
    checks++;
    if (done_seen !== d0 || busy !== 1'b0 || v !== '0) begin
      errors++;
      $display("FAIL midreset_no_commit: got done pulses=%0d busy=%b r2=%h required 0 0 00",
               done_seen - d0, busy, v);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_add();
    test_sub();
    test_shift_logic();
    test_busy_ignore();
    test_start_wr_same();
    test_back_to_back();
`ifdef SIGNED_FLAGS_EN
    test_signed_flags();
`endif
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion required completion");
    $fatal(1, "timeout");
  end

endmodule
